// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the MIPS datapath ALU slices.
//   - ALU_WIDTH      : datapath width (32 only)
//   - ALU_* codes    : 4-bit ALU control encodings from the ALU control decoder
//   - op_sel_e       : internal operation select for the ADD/AND/NOR slice
//   - decode_op()    : maps an ALU control code onto op_sel_e
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLL = 4'b1110;

   typedef enum logic [1:0] {
      OP_AND     = 2'd0,
      OP_ADD     = 2'd1,
      OP_NOR     = 2'd2,
      OP_ILLEGAL = 2'd3
   } op_sel_e;

   // SUB, SLT and SLL are served by other slices, so this slice treats them
   // as illegal just like any unassigned code.
   function automatic op_sel_e decode_op(input logic [3:0] ctl);
      op_sel_e sel;
      unique case (ctl)
         ALU_AND: sel = OP_AND;
         ALU_ADD: sel = OP_ADD;
         ALU_NOR: sel = OP_NOR;
         default: sel = OP_ILLEGAL;
      endcase
      return sel;
   endfunction

endpackage : alu_pkg

// File: rtl/add_and_nor_unit_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder_1bit
//   One bit cell of the ripple-carry adder.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in from the next lower bit
//     s     : sum bit
//     cout  : carry out to the next higher bit
// ---------------------------------------------------------------------------
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   // Propagate term is shared between the sum and the carry equations.
   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : full_adder_1bit

// File: rtl/add_and_nor_unit.sv
// ---------------------------------------------------------------------------
// add_and_nor_unit
//   Registered 32-bit ADD / AND / NOR slice of the MIPS datapath ALU.
//   A ripple-carry adder, an AND array and a NOR array run in parallel; the
//   ALU control code selects one, and the result plus flags are captured in
//   the output register on the edge where in_valid is high.
//   Ports:
//     clk         : rising-edge clock
//     reset       : asynchronous, active-high reset
//     in_valid    : request strobe, operands sampled when 1
//     ALUControl  : operation select (AND=0000, ADD=0010, NOR=1100)
//     rs, rt      : operands A and B
//     result      : registered result
//     zero        : registered, 1 when the accepted result is 0
//     carry       : registered carry-out of the top bit (ADD only)
//     overflow    : registered signed overflow (ADD only)
//     out_valid   : 1 for one cycle per accepted request
//     illegal_op  : registered, 1 when the accepted code is unsupported
// ---------------------------------------------------------------------------
module add_and_nor_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             out_valid,
   output logic             illegal_op
);

   // ------------------------------------------------------------------
   // Ripple-carry adder
   // ------------------------------------------------------------------
   logic [WIDTH:0]   chain;
   logic [WIDTH-1:0] sum;

   assign chain[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_adder
      full_adder_1bit u_fa (
         .a    (rs[i]),
         .b    (rt[i]),
         .cin  (chain[i]),
         .s    (sum[i]),
         .cout (chain[i+1])
      );
   end

   // ------------------------------------------------------------------
   // Bitwise AND / NOR arrays
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] and_out;
   logic [WIDTH-1:0] nor_out;

   for (genvar i = 0; i < WIDTH; i++) begin : g_logic
      assign and_out[i] = rs[i] & rt[i];
      assign nor_out[i] = ~(rs[i] | rt[i]);
   end

   // ------------------------------------------------------------------
   // Result / flag select
   // ------------------------------------------------------------------
   op_sel_e          sel;
   logic [WIDTH-1:0] next_result;
   logic             next_carry;
   logic             next_overflow;
   logic             legal;

   assign sel = decode_op(ALUControl);

   always_comb begin
      next_result   = '0;
      next_carry    = 1'b0;
      next_overflow = 1'b0;
      legal         = 1'b1;
      unique case (sel)
         OP_ADD: begin
            next_result   = sum;
            next_carry    = chain[WIDTH];
            // Same-sign operands whose sum flips sign.
            next_overflow = (rs[WIDTH-1] == rt[WIDTH-1]) &&
                            (sum[WIDTH-1] != rs[WIDTH-1]);
         end
         OP_AND: next_result = and_out;
         OP_NOR: next_result = nor_out;
         default: legal = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Output register
   //   An illegal request updates only illegal_op/out_valid; the datapath
   //   outputs keep the last legal result.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result     <= '0;
         zero       <= 1'b0;
         carry      <= 1'b0;
         overflow   <= 1'b0;
         out_valid  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            illegal_op <= ~legal;
            if (legal) begin
               result   <= next_result;
               zero     <= (next_result == '0);
               carry    <= next_carry;
               overflow <= next_overflow;
            end
         end
      end
   end

endmodule : add_and_nor_unit

// File: tb/tb_add_and_nor_unit.sv
// ---------------------------------------------------------------------------
// tb_add_and_nor_unit
//   Directed and random checks for add_and_nor_unit. Inputs change on the
//   falling edge; outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_add_and_nor_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [3:0]  ALUControl;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [31:0] result;
   logic        zero;
   logic        carry;
   logic        overflow;
   logic        out_valid;
   logic        illegal_op;

   int unsigned n_tests;
   int unsigned n_fail;

   // Reference state for the registered outputs.
   logic [31:0] exp_result;
   logic        exp_zero;
   logic        exp_carry;
   logic        exp_ovf;
   logic        exp_illegal;

   add_and_nor_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .ALUControl (ALUControl),
      .rs         (rs),
      .rt         (rt),
      .result     (result),
      .zero       (zero),
      .carry      (carry),
      .overflow   (overflow),
      .out_valid  (out_valid),
      .illegal_op (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic exp_ov);
      check({tag, ".result"},   result,            exp_result);
      check({tag, ".zero"},     {31'd0, zero},     {31'd0, exp_zero});
      check({tag, ".carry"},    {31'd0, carry},    {31'd0, exp_carry});
      check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
      check({tag, ".illegal"},  {31'd0, illegal_op}, {31'd0, exp_illegal});
      check({tag, ".valid"},    {31'd0, out_valid}, {31'd0, exp_ov});
   endtask

   // Behavioural reference of one accepted request.
   task automatic model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      exp_illegal = 1'b0;
      case (ctl)
         4'b0010: begin
            exp_result = s[31:0];
            exp_carry  = s[32];
            exp_ovf    = (a[31] == b[31]) && (s[31] != a[31]);
         end
         4'b0000: begin
            exp_result = a & b;
            exp_carry  = 1'b0;
            exp_ovf    = 1'b0;
         end
         4'b1100: begin
            exp_result = ~(a | b);
            exp_carry  = 1'b0;
            exp_ovf    = 1'b0;
         end
         default: exp_illegal = 1'b1;
      endcase
      if (!exp_illegal) exp_zero = (exp_result == 32'd0);
   endtask

   // Drive one request, leave in_valid high so calls chain back-to-back.
   task automatic do_op(input string tag, input logic [3:0] ctl,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid   = 1'b1;
      ALUControl = ctl;
      rs         = a;
      rt         = b;
      @(posedge clk);
      #1;
      model(ctl, a, b);
      check_all(tag, 1'b1);
   endtask

   // Idle cycle with scrambled operands that must be ignored.
   task automatic idle(input string tag);
      @(negedge clk);
      in_valid   = 1'b0;
      ALUControl = 4'b0010;
      rs         = $urandom;
      rt         = $urandom;
      @(posedge clk);
      #1;
      check_all(tag, 1'b0);
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      exp_result  = '0;
      exp_zero    = 1'b0;
      exp_carry   = 1'b0;
      exp_ovf     = 1'b0;
      exp_illegal = 1'b0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      ALUControl  = 4'b0000;
      rs          = '0;
      rt          = '0;

      #1;
      check_all("reset0", 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle("post_reset");

      // Directed ADD cases
      do_op("add_5_3", 4'b0010, 32'h0000_0005, 32'h0000_0003);
      check("add_5_3.val", result, 32'h0000_0008);
      do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
      check("add_wrap.val", {zero, carry, overflow, result[28:0]}, {3'b110, 29'd0});
      do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
      check("add_ovf.val", result, 32'h8000_0000);
      check("add_ovf.flags", {30'd0, carry, overflow}, 32'd1);

      // AND / NOR
      do_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("and.val", result, 32'hF000_F000);
      do_op("nor", 4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("nor.val", result, 32'h000F_000F);
      do_op("nor_zero", 4'b1100, 32'hFFFF_FFFF, 32'h0000_0000);
      check("nor_zero.val", {zero, carry, result[29:0]}, {2'b10, 30'd0});

      // Illegal code holds the datapath outputs, then idle holds everything
      do_op("add_8", 4'b0010, 32'h0000_0005, 32'h0000_0003);
      do_op("illegal", 4'b0110, 32'h1234_5678, 32'h1111_1111);
      check("illegal.val", {illegal_op, out_valid, result[29:0]}, {2'b11, 30'd8});
      repeat (3) idle("hold");
      check("hold.val", result, 32'h0000_0008);

      // Back-to-back throughput
      do_op("bb0", 4'b0010, 32'h0000_0010, 32'h0000_0020);
      check("bb0.val", result, 32'h0000_0030);
      do_op("bb1", 4'b0000, 32'h0000_FFFF, 32'h00FF_00FF);
      check("bb1.val", result, 32'h0000_00FF);
      do_op("bb2", 4'b1100, 32'h0000_FFFF, 32'h00FF_00FF);
      check("bb2.val", result, 32'hFF00_0000);
      do_op("bb3", 4'b0010, 32'h8000_0000, 32'h8000_0000);
      check("bb3.val", {carry, overflow, zero, result[28:0]}, {3'b111, 29'd0});
      idle("bb_end");

      // Reset mid-stream: clears outputs at once and drops the request
      do_op("pre_rst", 4'b0010, 32'h0000_0100, 32'h0000_0001);
      @(negedge clk);
      in_valid   = 1'b1;
      ALUControl = 4'b0010;
      rs         = 32'h0000_0042;
      rt         = 32'h0000_0001;
      #2;
      reset = 1'b1;
      #1;
      exp_result  = '0;
      exp_zero    = 1'b0;
      exp_carry   = 1'b0;
      exp_ovf     = 1'b0;
      exp_illegal = 1'b0;
      check_all("rst_async", 1'b0);
      @(posedge clk);
      #1;
      check_all("rst_held", 1'b0);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_all("rst_release", 1'b0);

      // Random operands for each legal op
      for (int k = 0; k < 3; k++) begin
         logic [3:0] ctl;
         ctl = (k == 0) ? 4'b0010 : (k == 1) ? 4'b0000 : 4'b1100;
         for (int i = 0; i < 1000; i++) begin
            do_op("rand", ctl, $urandom, $urandom);
         end
      end
      idle("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_add_and_nor_unit

// File: doc/add_and_nor_unit.md
# add_and_nor_unit

Registered 32-bit arithmetic/logic slice providing the ADD, AND and NOR operations of the MIPS datapath ALU. It combines a ripple-carry adder with a bitwise AND array and a bitwise NOR array, and selects one of them with the standard 4-bit ALU control code. The selected result and flags are captured in an output register one cycle after a valid request. The block sits between the ALU control decoder and the result/flag consumers: register-file write-back and branch-zero logic.

## Interface
- WIDTH, 32: operand and result width. Only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request strobe; operands are sampled on the clk edge where this is 1.
- ALUControl  input  4  operation select: AND=0000, ADD=0010, NOR=1100.
- rs  input  32  operand A.
- rt  input  32  operand B, either a register value or a sign-extended immediate.
- result  output  32  registered result.
- zero  output  1  registered; 1 when the result of an accepted op is 0.
- carry  output  1  registered carry-out of bit 31 (ADD only).
- overflow  output  1  registered signed overflow (ADD only).
- out_valid  output  1  1 for exactly one cycle per accepted request.
- illegal_op  output  1  registered; 1 when the accepted ALUControl is not one of the three codes.

## Operation
- ADD: result = (rs + rt) mod 2^32, unsigned wrap.
  - carry = bit 32 of the 33-bit sum.
  - overflow = (rs[31] == rt[31]) && (sum[31] != rs[31]).
- AND: result = rs & rt; carry = 0, overflow = 0.
- NOR: result = ~(rs | rt); carry = 0, overflow = 0.
- zero = (next result == 0), evaluated on the value being registered.
- Any other ALUControl code:
  - result, zero, carry and overflow hold their previous values.
  - illegal_op = 1, and out_valid still pulses.
- For a legal op, illegal_op = 0.
- All datapath logic is combinational. Only the output register holds state.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on the outputs after edge N, with out_valid = 1 during cycle N+1.
- Back-to-back requests are accepted every cycle. There is no back-pressure.
- in_valid = 0 at an edge:
  - out_valid goes to 0.
  - result and all flags hold their values.
- Reset values (asserted immediately, not at a clock edge):
  - result = 0
  - zero = 0, even though result is 0
  - carry = 0, overflow = 0
  - out_valid = 0, illegal_op = 0
- Reset during an operation: the in-flight request is dropped and no out_valid is produced for it.
- Reset has priority over in_valid. The first request is accepted at the first edge after reset deasserts.
- Changing ALUControl, rs or rt while in_valid = 0 has no effect on the outputs.

## Structure
- Shared package (alu_pkg):
  - ALU control constants: ALU_AND=4'b0000, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_SLL=4'b1110.
  - ALU_WIDTH=32.
- One natural sub-module: full_adder_1bit (a, b, cin → s, cout), instantiated 32 times as a ripple chain with cin[0]=0.
- The AND and NOR arrays are generate loops of 2-input gates.
- The output register is a single always block with asynchronous reset.

## Test plan
- Reset: assert reset mid-stream → all outputs 0 immediately. After release with no request, out_valid stays 0.
- ADD:
  - rs=0x0000_0005, rt=0x0000_0003 → result 0x0000_0008, carry 0, overflow 0, zero 0; out_valid high one cycle later.
  - rs=0xFFFF_FFFF, rt=0x0000_0001 → result 0, carry 1, overflow 0, zero 1.
  - rs=0x7FFF_FFFF, rt=0x0000_0001 → result 0x8000_0000, overflow 1, carry 0.
- AND/NOR:
  - AND, rs=0xF0F0_F0F0, rt=0xFF00_FF00 → result 0xF000_F000.
  - NOR, same operands → result 0x000F_000F.
  - NOR, rs=0xFFFF_FFFF, rt=0 → result 0, zero 1, carry 0.
- Illegal code and hold:
  - After an ADD producing 0x8, ALUControl=0110 → result stays 0x8, illegal_op 1, out_valid pulses.
  - Then in_valid=0 for 3 cycles → outputs hold, out_valid 0.
- Throughput: 4 consecutive requests (ADD, AND, NOR, ADD) → 4 consecutive out_valid cycles with correct results in order.
- Random: 1000 random operand pairs per legal op, checked against a reference model for result, zero, carry and overflow.
